// File: rtl/food_spawner.sv
// food_spawner: turns the free-running random word stream into a free board
// cell for the Snake game. Each candidate is checked against the occupancy
// store through a one-cycle read port, and the search gives up after
// MAX_TRIES candidates.
// Optional feature macro: FOOD_FALLBACK_SCAN_EN. When defined, an exhausted
// random search falls back to a row-major scan of the whole board.
module food_spawner #(
    parameter int WIDTH     = 32,
    parameter int COLS      = 40,
    parameter int ROWS      = 30,
    parameter int X_W       = 6,
    parameter int Y_W       = 5,
    parameter int MAX_TRIES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rand_in,
    input  logic             spawn_req,
    output logic             occ_rd,
    output logic [X_W-1:0]   occ_x,
    output logic [Y_W-1:0]   occ_y,
    input  logic             occ_hit,
    output logic [X_W-1:0]   food_x,
    output logic [Y_W-1:0]   food_y,
    output logic             food_valid,
    output logic             fail,
    output logic             busy
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [X_W:0] COLS_L = (X_W + 1)'(COLS);
    localparam logic [Y_W:0] ROWS_L = (Y_W + 1)'(ROWS);

`ifdef FOOD_FALLBACK_SCAN_EN
    typedef enum logic [2:0] {IDLE, SAMPLE, REQ, WAIT, SCAN_REQ, SCAN_WAIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, SAMPLE, REQ, WAIT} state_t;
`endif

    state_t         state_q, state_d;
    logic [TW-1:0]  tries_q, tries_d;
    logic           occ_rd_q, occ_rd_d;
    logic [X_W-1:0] occ_x_q, occ_x_d;
    logic [Y_W-1:0] occ_y_q, occ_y_d;
    logic [X_W-1:0] food_x_q, food_x_d;
    logic [Y_W-1:0] food_y_q, food_y_d;
    logic           food_valid_q, food_valid_d;
    logic           fail_q, fail_d;
    logic           busy_q, busy_d;

    // Candidate cell taken straight from the random word; no modulo, so
    // out-of-range values are simply rejected.
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
    logic           in_range;
    logic [TW-1:0]  tries_inc;
    logic           exhausted;
    logic           go_exhaust;
    logic           unused_rand;

    assign cx          = rand_in[X_W-1:0];
    assign cy          = rand_in[X_W+Y_W-1:X_W];
    assign in_range    = ({1'b0, cx} < COLS_L) && ({1'b0, cy} < ROWS_L);
    assign tries_inc   = tries_q + TW'(1);
    assign exhausted   = (tries_inc == TW'(MAX_TRIES));
    assign unused_rand = ^rand_in;

    // Next-state and next-output logic for the search FSM.
    always_comb begin
        state_d      = state_q;
        tries_d      = tries_q;
        occ_rd_d     = 1'b0;
        occ_x_d      = occ_x_q;
        occ_y_d      = occ_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = 1'b0;
        fail_d       = 1'b0;
        busy_d       = busy_q;
        go_exhaust   = 1'b0;

        case (state_q)
            IDLE: begin
                if (spawn_req) begin
                    state_d = SAMPLE;
                    busy_d  = 1'b1;
                    tries_d = '0;
                end
            end
            SAMPLE: begin
                if (in_range) begin
                    occ_x_d  = cx;
                    occ_y_d  = cy;
                    occ_rd_d = 1'b1;
                    state_d  = REQ;
                end else begin
                    tries_d = tries_inc;
                    if (exhausted) go_exhaust = 1'b1;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!occ_hit) begin
                    food_x_d     = occ_x_q;
                    food_y_d     = occ_y_q;
                    food_valid_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end else begin
                    tries_d = tries_inc;
                    if (exhausted) go_exhaust = 1'b1;
                    else           state_d    = SAMPLE;
                end
            end
`ifdef FOOD_FALLBACK_SCAN_EN
            SCAN_REQ: begin
                state_d = SCAN_WAIT;
            end
            SCAN_WAIT: begin
                if (!occ_hit) begin
                    food_x_d     = occ_x_q;
                    food_y_d     = occ_y_q;
                    food_valid_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end else if (occ_x_q == X_W'(COLS - 1) && occ_y_q == Y_W'(ROWS - 1)) begin
                    // Last cell occupied: board is full.
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (occ_x_q == X_W'(COLS - 1)) begin
                        occ_x_d = '0;
                        occ_y_d = occ_y_q + Y_W'(1);
                    end else begin
                        occ_x_d = occ_x_q + X_W'(1);
                    end
                    occ_rd_d = 1'b1;
                    state_d  = SCAN_REQ;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Exhaustion wins over continuing the random search.
        if (go_exhaust) begin
`ifdef FOOD_FALLBACK_SCAN_EN
            occ_x_d  = '0;
            occ_y_d  = '0;
            occ_rd_d = 1'b1;
            state_d  = SCAN_REQ;
`else
            fail_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
`endif
        end
    end

    // State and registered outputs; reset abandons any search in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tries_q      <= '0;
            occ_rd_q     <= 1'b0;
            occ_x_q      <= '0;
            occ_y_q      <= '0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
            fail_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tries_q      <= tries_d;
            occ_rd_q     <= occ_rd_d;
            occ_x_q      <= occ_x_d;
            occ_y_q      <= occ_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            fail_q       <= fail_d;
            busy_q       <= busy_d;
        end
    end

    assign occ_rd     = occ_rd_q;
    assign occ_x      = occ_x_q;
    assign occ_y      = occ_y_q;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign fail       = fail_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_food_spawner.sv
// tb_food_spawner: directed phases followed by random traffic against a
// transaction-level timeline model of the spawner. Honours
// FOOD_FALLBACK_SCAN_EN in the same way as the design.
module tb_food_spawner;

    localparam int COLS = 40;
    localparam int ROWS = 30;
    localparam int MAXT = 4;
    localparam int N    = 11600;
`ifdef FOOD_FALLBACK_SCAN_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rand_in;
    logic        spawn_req;
    logic        occ_rd;
    logic [5:0]  occ_x;
    logic [4:0]  occ_y;
    logic        occ_hit;
    logic [5:0]  food_x;
    logic [4:0]  food_y;
    logic        food_valid;
    logic        fail;
    logic        busy;

    food_spawner #(
        .WIDTH(32), .COLS(COLS), .ROWS(ROWS), .X_W(6), .Y_W(5), .MAX_TRIES(MAXT)
    ) dut (
        .clk(clk), .reset(reset), .rand_in(rand_in), .spawn_req(spawn_req),
        .occ_rd(occ_rd), .occ_x(occ_x), .occ_y(occ_y), .occ_hit(occ_hit),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .fail(fail), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stimulus schedule and expected per-cycle timeline.
    logic [31:0] rand_seq [N];
    bit          spawn_sch[N];
    bit          rst_sch  [N];
    bit          exp_rst  [N];
    bit          exp_rd   [N];
    int          exp_x    [N];
    int          exp_y    [N];
    bit          exp_fv   [N];
    bit          exp_fail [N];
    bit          exp_busy [N];
    int          exp_fx   [N];
    int          exp_fy   [N];
    bit          board[COLS][ROWS];

    int n_cmp = 0;
    int n_err = 0;
    int cur_k = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cur_k, got, exp);
        end
    endtask

    task automatic board_all(input bit v);
        for (int x = 0; x < COLS; x++)
            for (int y = 0; y < ROWS; y++) board[x][y] = v;
    endtask

    // Random occupancy; one free cell in row 0 keeps any fallback scan short.
    task automatic board_rand(input int pct);
        for (int x = 0; x < COLS; x++)
            for (int y = 0; y < ROWS; y++) board[x][y] = ($urandom_range(99) < pct);
        board[COLS-1][0] = 1'b0;
    endtask

    task automatic q_rd(input int c, input int x, input int y);
        if (c < N) begin exp_rd[c] = 1'b1; exp_x[c] = x; exp_y[c] = y; end
    endtask

    task automatic set_busy(input int t, input int e);
        for (int j = t + 1; j < e && j < N; j++) exp_busy[j] = 1'b1;
    endtask

    // Expected timeline of one accepted request issued in cycle t: one
    // sample cycle per candidate, +2 cycles for a lookup, result the cycle
    // after the lookup answer.
    task automatic predict(input int t);
        int  c, tries, n, cx, cy;
        bit  done;
        c = t + 1; tries = 0; n = -1; done = 1'b0;
        while (!done && n < 0 && c < N - 8) begin
            cx = int'(rand_seq[c][5:0]);
            cy = int'(rand_seq[c][10:6]);
            if (cx < COLS && cy < ROWS) begin
                q_rd(c + 1, cx, cy);
                if (!board[cx][cy]) begin
                    set_busy(t, c + 3);
                    exp_fv[c+3] = 1'b1; exp_fx[c+3] = cx; exp_fy[c+3] = cy;
                    done = 1'b1;
                end else begin
                    tries++;
                    if (tries == MAXT) n = c + 3; else c = c + 3;
                end
            end else begin
                tries++;
                if (tries == MAXT) n = c + 1; else c = c + 1;
            end
        end
        if (!done && n >= 0) begin
            if (SCAN) begin
                for (int i = 0; i < COLS * ROWS && !done; i++) begin
                    cx = i % COLS; cy = i / COLS;
                    q_rd(n, cx, cy);
                    if (!board[cx][cy]) begin
                        set_busy(t, n + 2);
                        exp_fv[n+2] = 1'b1; exp_fx[n+2] = cx; exp_fy[n+2] = cy;
                        done = 1'b1;
                    end else n += 2;
                end
            end
            if (!done && n < N) begin
                set_busy(t, n);
                exp_fail[n] = 1'b1;
            end
        end
    endtask

    // Reset in cycle k wipes everything expected afterwards.
    task automatic clear_after(input int k);
        for (int j = k + 1; j < N; j++) begin
            exp_rd[j] = 1'b0; exp_fv[j] = 1'b0; exp_fail[j] = 1'b0; exp_busy[j] = 1'b0;
        end
        if (k + 1 < N) exp_rst[k+1] = 1'b1;
    endtask

    initial begin
        int cur_fx, cur_fy, px, py;
        bit rd_prev;
        int c_rd, c_fail, c_fv;

        for (int k = 0; k < N; k++) begin
            rand_seq[k] = (k < 3100) ? 32'h0000_0503 : $urandom;
            spawn_sch[k] = 1'b0; rst_sch[k] = 1'b0; exp_rst[k] = 1'b0;
            exp_rd[k] = 1'b0; exp_fv[k] = 1'b0; exp_fail[k] = 1'b0; exp_busy[k] = 1'b0;
            exp_x[k] = 0; exp_y[k] = 0; exp_fx[k] = 0; exp_fy[k] = 0;
            if ((k >= 3100 && k < 6800) || (k >= 7000 && k < 11200)) begin
                spawn_sch[k] = ($urandom_range(5) == 0);
                rst_sch[k]   = ($urandom_range(499) == 0);
            end
        end
        for (int k = 0; k < 5; k++) rst_sch[k] = 1'b1;
        for (int k = 31; k < 34; k++) rand_seq[k] = 32'h0000_003F;
        spawn_sch[10] = 1'b1;     // best case
        spawn_sch[30] = 1'b1;     // three range rejects
        spawn_sch[60] = 1'b1;     // all hits except (2,0)
        spawn_sch[120] = 1'b1;    // full board
        spawn_sch[3000] = 1'b1;   // reset lands in WAIT
        rst_sch[3003] = 1'b1;
        spawn_sch[3010] = 1'b1;
        spawn_sch[3012] = 1'b1;   // while busy: ignored
        exp_rst[0] = 1'b1;

        board_all(1'b0);
        reset = 1'b1; spawn_req = 1'b0; rand_in = '0; occ_hit = 1'b0;
        cur_fx = 0; cur_fy = 0; rd_prev = 1'b0; px = 0; py = 0;
        c_rd = 0; c_fail = 0; c_fv = 0;

        for (int k = 0; k < N; k++) begin
            @(posedge clk); #1;
            cur_k = k;
            if (k == 55)   begin board_all(1'b1); board[2][0] = 1'b0; end
            if (k == 115)  board_all(1'b1);
            if (k == 2990) board_all(1'b0);
            if (k == 3090) board_rand(30);
            if (k == 6950) board_rand(85);
            reset     = rst_sch[k];
            rand_in   = rand_seq[k];
            spawn_req = spawn_sch[k];
            if (rd_prev) occ_hit = (px < COLS && py < ROWS) ? board[px][py] : 1'b1;
            else         occ_hit = 1'($urandom_range(1));
            if (rst_sch[k])                      clear_after(k);
            else if (spawn_sch[k] && !exp_busy[k]) predict(k);

            @(negedge clk);
            if (exp_rst[k]) begin
                cur_fx = 0; cur_fy = 0;
                chk("rst_occ_x", 32'(occ_x), 32'd0);
                chk("rst_occ_y", 32'(occ_y), 32'd0);
            end
            if (exp_fv[k]) begin cur_fx = exp_fx[k]; cur_fy = exp_fy[k]; end
            chk("occ_rd", 32'(occ_rd), 32'(exp_rd[k]));
            if (exp_rd[k]) begin
                chk("occ_x", 32'(occ_x), exp_x[k]);
                chk("occ_y", 32'(occ_y), exp_y[k]);
            end
            chk("food_valid", 32'(food_valid), 32'(exp_fv[k]));
            chk("fail", 32'(fail), 32'(exp_fail[k]));
            chk("busy", 32'(busy), 32'(exp_busy[k]));
            chk("food_x", 32'(food_x), cur_fx);
            chk("food_y", 32'(food_y), cur_fy);

            // Directed spot checks from hand-worked timing.
            if (k == 12) begin
                chk("t1_occ_rd", 32'(occ_rd), 32'd1);
                chk("t1_occ_x", 32'(occ_x), 32'd3);
                chk("t1_occ_y", 32'(occ_y), 32'd20);
            end
            if (k == 14) begin
                chk("t1_fv", 32'(food_valid), 32'd1);
                chk("t1_fx", 32'(food_x), 32'd3);
                chk("t1_fy", 32'(food_y), 32'd20);
            end
            if (k == 36) chk("t2_fv_early", 32'(food_valid), 32'd0);
            if (k == 37) chk("t2_fv", 32'(food_valid), 32'd1);
            if (k == 3004) begin
                chk("t6_busy", 32'(busy), 32'd0);
                chk("t6_fx", 32'(food_x), 32'd0);
                chk("t6_fy", 32'(food_y), 32'd0);
            end

            if (k == 60 || k == 120 || k == 3005) begin c_rd = 0; c_fail = 0; c_fv = 0; end
            c_rd += int'(occ_rd); c_fail += int'(fail); c_fv += int'(food_valid);
            if (k == 119) begin
                chk("t3_rd_cnt", c_rd, SCAN ? 7 : 4);
                chk("t3_fail_cnt", c_fail, SCAN ? 0 : 1);
                chk("t3_fv_cnt", c_fv, SCAN ? 1 : 0);
                chk("t3_fx", 32'(food_x), SCAN ? 2 : 3);
                chk("t3_fy", 32'(food_y), SCAN ? 0 : 20);
            end
            if (k == 2989) begin
                chk("t5_rd_cnt", c_rd, SCAN ? 4 + COLS * ROWS : 4);
                chk("t5_fail_cnt", c_fail, 1);
                chk("t5_fv_cnt", c_fv, 0);
            end
            if (k == 3099) chk("t6_fv_cnt", c_fv, 1);

            rd_prev = occ_rd;
            px = int'(occ_x);
            py = int'(occ_y);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
